// File: rtl/jpeg_stream_sequencer.sv
// Frame controller around the JPEG output stage: frame FIFO, 1-padded tail word, SOI/EOI framing.
// Define JPEG_SEQ_MARKERS_EN to emit SOI/EOI markers; otherwise out_last flags the final word.
module jpeg_stream_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned EOF_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        frame_end,
  output logic        enc_enable,
  output logic        enc_eof,
  input  logic [31:0] enc_data,
  input  logic        enc_data_ready,
  input  logic [4:0]  enc_eof_count,
  input  logic        enc_eof_partial,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        overflow,
  output logic        eof_timeout
);

`ifdef JPEG_SEQ_MARKERS_EN
  localparam bit Markers = 1'b1;
`else
  localparam bit Markers = 1'b0;
`endif

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(EOF_TIMEOUT) + 1;
  localparam logic [AW:0] CntFull = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CntOne  = (AW + 1)'(1);

  typedef enum logic [2:0] {
    StIdle, StSoi, StStream, StWaitEof, StDrain, StTail, StEoi
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   tail_data_q, tail_data_d;
  logic [4:0]    tail_cnt_q, tail_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          eof_q, eof_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;

  logic          push_req, push_ok, pop, fifo_full, fifo_empty;
  logic [31:0]   tail_padded, tail_word;
  logic [2:0]    tail_n, tail_bytes;
  logic [7:0]    tail_lsb;
  logic          tail_ff, stuff_pend;

  assign fifo_full   = (count_q == CntFull);
  assign fifo_empty  = (count_q == '0);
  assign enc_eof     = eof_q;
  assign busy        = (state_q != StIdle);
  assign overflow    = overflow_q;
  assign eof_timeout = timeout_q;

  // Tail word: captured bits padded with ones, then 0xFF stuffing on its last valid byte.
  always_comb begin
    tail_padded = tail_data_q | (32'hFFFF_FFFF >> tail_cnt_q);
    tail_n      = 3'((6'(tail_cnt_q) + 6'd7) >> 3);
    case (tail_n)
      3'd1:    tail_lsb = tail_padded[31:24];
      3'd2:    tail_lsb = tail_padded[23:16];
      3'd3:    tail_lsb = tail_padded[15:8];
      default: tail_lsb = tail_padded[7:0];
    endcase
    tail_ff    = (tail_cnt_q != 5'd0) && (tail_lsb == 8'hFF);
    stuff_pend = tail_ff && (tail_n == 3'd4);
    tail_word  = tail_padded;
    tail_bytes = tail_n;
    if (tail_ff && !stuff_pend) begin
      // Stuffed 0x00 follows the last valid byte; everything below it is zero.
      tail_word  = tail_padded & ~(32'hFFFF_FFFF >> {tail_n, 3'b000});
      tail_bytes = tail_n + 3'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    tail_data_d = tail_data_q;
    tail_cnt_d  = tail_cnt_q;
    tmo_d       = tmo_q;
    eof_d       = 1'b0;
    overflow_d  = overflow_q;
    timeout_d   = timeout_q;
    enc_enable  = 1'b0;
    out_valid   = 1'b0;
    out_data    = 32'h0;
    out_bytes   = 3'd0;
    out_last    = 1'b0;
    push_req    = 1'b0;
    pop         = 1'b0;
    push_ok     = 1'b0;

    if (state_q inside {StStream, StWaitEof, StDrain}) begin
      out_valid = !fifo_empty;
      out_data  = fifo_empty ? 32'h0 : mem[rd_ptr_q];
      out_bytes = fifo_empty ? 3'd0 : 3'd4;
      pop       = !fifo_empty && out_ready;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          rd_ptr_d    = '0;
          wr_ptr_d    = '0;
          count_d     = '0;
          tail_data_d = 32'h0;
          tail_cnt_d  = 5'd0;
          tmo_d       = '0;
          overflow_d  = 1'b0;
          timeout_d   = 1'b0;
          state_d     = Markers ? StSoi : StStream;
        end
      end
      StSoi: begin
        out_valid = 1'b1;
        out_data  = 32'hFFD8_0000;
        out_bytes = 3'd2;
        if (out_ready) state_d = StStream;
      end
      StStream: begin
        enc_enable = 1'b1;
        push_req   = enc_data_ready;
        if (frame_end) begin
          eof_d   = 1'b1;
          tmo_d   = '0;
          state_d = StWaitEof;
        end
      end
      StWaitEof: begin
        enc_enable = 1'b1;
        push_req   = enc_data_ready;
        if (enc_eof_partial) begin
          tail_data_d = enc_data;
          tail_cnt_d  = enc_eof_count;
          tmo_d       = '0;
          state_d     = StDrain;
        end else if (tmo_q == TW'(EOF_TIMEOUT - 1)) begin
          timeout_d  = 1'b1;
          tail_cnt_d = 5'd0;
          state_d    = StDrain;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StDrain: begin
        // Without markers and without a tail, the last FIFO word closes the frame.
        out_last = !Markers && (count_q == CntOne) && (tail_cnt_q == 5'd0);
        if (fifo_empty || ((count_q == CntOne) && pop)) begin
          if (tail_cnt_q != 5'd0) state_d = StTail;
          else                    state_d = Markers ? StEoi : StIdle;
        end
      end
      StTail: begin
        out_valid = 1'b1;
        out_data  = tail_word;
        out_bytes = tail_bytes;
        out_last  = !Markers && !stuff_pend;
        if (out_ready) state_d = (Markers || stuff_pend) ? StEoi : StIdle;
      end
      StEoi: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        if (!Markers) begin
          out_data  = 32'h0;
          out_bytes = 3'd1;
        end else if (stuff_pend) begin
          out_data  = 32'h00FF_D900;
          out_bytes = 3'd3;
        end else begin
          out_data  = 32'hFFD9_0000;
          out_bytes = 3'd2;
        end
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A full FIFO drops the word even if a pop frees a slot this cycle.
    push_ok = push_req && !fifo_full;
    if (push_req && fifo_full) overflow_d = 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + CntOne;
    else if (!push_ok && pop) count_d = count_q - CntOne;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      tail_data_q <= 32'h0;
      tail_cnt_q  <= 5'd0;
      tmo_q       <= '0;
      eof_q       <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      tail_data_q <= tail_data_d;
      tail_cnt_q  <= tail_cnt_d;
      tmo_q       <= tmo_d;
      eof_q       <= eof_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= enc_data;
  end

endmodule

// File: doc/jpeg_stream_sequencer.md
# jpeg_stream_sequencer

Frame-level controller wrapped around the JPEG output stage (FIFO packer plus 0xFF stuffer). It starts a frame, drives the output stage's `enable` and `end_of_file_signal`, and brackets the entropy-coded data with SOI and EOI markers. It buffers the stage's 32-bit words in a small FIFO so a downstream valid/ready sink can stall, and closes the frame with a 1-padded partial tail word. It sits between the encoder output stage and the system bus/DMA writer.

## Interface
- `FIFO_DEPTH`, 8 — data FIFO entries; power of two, 4 to 64.
- `EOF_TIMEOUT`, 64 — cycles to wait for the stage's end-of-file response after `enc_eof` is asserted.
- `clk` in 1 — single clock; all logic on the rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle frame start; honoured only in IDLE.
- `frame_end` in 1 — one-cycle pulse: last pixel block has been fed to the encoder; honoured only in STREAM.
- `enc_enable` out 1 — drives the output stage's `enable`.
- `enc_eof` out 1 — one-cycle pulse to the stage's `end_of_file_signal`.
- `enc_data` in 32 — stage `JPEG_bitstream`.
- `enc_data_ready` in 1 — stage `data_ready`; one word per asserted cycle.
- `enc_eof_count` in 5 — stage `end_of_file_bitstream_count`: valid MSB bits of the tail.
- `enc_eof_partial` in 1 — stage `eof_data_partial_ready`.
- `out_data` out 32 — output word, MSB byte first.
- `out_bytes` out 3 — number of valid bytes (1–4), MSB-aligned.
- `out_valid` out 1 — output word valid.
- `out_ready` in 1 — sink accepts.
- `out_last` out 1 — last word of the frame.
- `busy` out 1 — high in any state other than IDLE.
- `overflow` out 1 — sticky: a word was dropped because the FIFO was full.
- `eof_timeout` out 1 — sticky: the tail response never arrived.

## Operation
- FSM states: IDLE, SOI, STREAM, WAIT_EOF, DRAIN, TAIL, EOI.
- **IDLE**
  - `start` → SOI.
  - Clears `overflow`, `eof_timeout`, the FIFO and the tail registers.
- **SOI**
  - Presents `0xFFD80000`, `out_bytes`=2.
  - On handshake → STREAM.
- **STREAM**
  - `enc_enable`=1.
  - Each `enc_data_ready` pushes `enc_data` into the FIFO (`out_bytes`=4).
  - The FIFO head is presented on the output.
  - `frame_end` → pulse `enc_eof` for one cycle → WAIT_EOF.
- **WAIT_EOF**
  - `enc_enable` stays 1 and FIFO pushes continue.
  - On `enc_eof_partial`, capture `enc_data`/`enc_eof_count` into the tail registers; the cycle counter resets → DRAIN.
  - If the counter reaches `EOF_TIMEOUT`: set `eof_timeout`, tail count=0 → DRAIN.
- **DRAIN**
  - `enc_enable`=0.
  - Pops the FIFO until it is empty.
  - Then → TAIL if tail count>0, else → EOI.
- **TAIL**
  - Word = captured data OR (`0xFFFFFFFF` >> count): 1-padding to a byte boundary.
  - `out_bytes` = (count+7)>>3.
  - If the last valid byte is 0xFF and `out_bytes`<4: append 0x00 and increment `out_bytes`.
  - If the last valid byte is 0xFF and `out_bytes`==4: set the stuff-pending flag.
  - On handshake → EOI.
- **EOI**
  - Presents `0xFFD90000`, `out_bytes`=2.
  - With stuff pending it presents `0x00FFD900`, `out_bytes`=3.
  - `out_last`=1. On handshake → IDLE.
- Handshake: a word transfers on a cycle with `out_valid`&&`out_ready`. While stalled, `out_data`, `out_bytes` and `out_last` are held stable.
- FIFO full and `enc_data_ready` in the same cycle: the word is dropped and `overflow` is set. A simultaneous pop does not free a slot for that push.
- `enc_data_ready` and `enc_eof_partial` in the same cycle: the word is pushed and the tail is captured, in that order.
- `start` outside IDLE and `frame_end` outside STREAM are ignored.
- Reset mid-frame: all state is discarded immediately and there is no EOI.

## Timing
- Reset values:
  - `enc_enable`, `enc_eof`, `out_valid`, `out_last`, `busy`, `overflow`, `eof_timeout` = 0.
  - `out_data` = 0, `out_bytes` = 0.
  - FSM = IDLE.
- `start` at cycle N → `out_valid` (SOI) at N+1.
- FIFO latency: a push at cycle N on an empty FIFO is visible at N+1.
- Throughput: one word per cycle when `out_ready`=1.
- `enc_eof` is high exactly one cycle, the cycle after `frame_end`.
- State transitions are registered: DRAIN→TAIL/EOI takes effect the cycle after the last pop handshake.

## Configuration
- `JPEG_SEQ_MARKERS_EN` defined:
  - SOI and EOI are emitted as described above.
- Not defined:
  - SOI and EOI states are skipped; IDLE→STREAM directly on `start`.
  - `out_last` is raised on the TAIL word.
  - If the tail count is 0, `out_last` is raised on the final FIFO word instead.
  - A pending stuff byte is emitted as a lone word `0x00000000` with `out_bytes`=1 and `out_last`=1.

## Test plan
- Frame of 3 data words (`0x11223344`…), eof count=12, data `0xABC00000`, `out_ready`=1 → SOI; 3 words; tail `0xABCFFFFF` with bytes=2; EOI with `out_last`; `busy` falls after EOI.
- Tail count=8, data `0xFF000000` → tail `0xFF000000` bytes=2 (stuffed 0x00); tail count=32-bit-edge case 31, data `0xFFFFFFFE` → tail bytes=4, EOI `0x00FFD900` bytes=3.
- `FIFO_DEPTH`=4, `out_ready`=0, 6 `enc_data_ready` pulses → `overflow`=1, exactly 4 words delivered after release, in order.
- `out_ready` toggled every other cycle → every word held stable while stalled; no loss, no duplication.
- No `enc_eof_partial` after `frame_end` → `eof_timeout`=1 after 64 cycles; no tail word; EOI is the last word.
- `rst` low during STREAM → all outputs return to reset values asynchronously; next `start` yields a clean SOI.
